// File: rtl/ex_stage_if.sv
// ============================================================================
// Module      : ex_stage_if
// Description : ID/EX control and operands, forwarding sources and EX/MEM
//               results for the RV32I execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_stage_if;
  logic        RegWrite_i;
  logic        ALUSrc_i;
  logic        Branch_i;
  logic        J_i;
  logic        Jalr_i;
  logic [1:0]  Shift_i;
  logic [3:0]  ALUControl_i;
  logic [2:0]  Compare_i;
  logic [31:0] imme_i;
  logic [31:0] rdata1_i;
  logic [31:0] rdata2_i;
  logic [31:0] instr_i;
  logic [13:0] addr_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [4:0]  mem_rd_i;
  logic        mem_regwrite_i;
  logic [31:0] mem_result_i;
  logic [4:0]  wb_rd_i;
  logic        wb_regwrite_i;
  logic [31:0] wb_result_i;
  logic [31:0] alu_result_o;
  logic [31:0] store_data_o;
  logic [4:0]  rd_o;
  logic        RegWrite_o;
  logic [31:0] instr_o;
  logic        redirect_o;
  logic [13:0] target_o;
  logic        stall_o;

  modport master (
    output RegWrite_i, ALUSrc_i, Branch_i, J_i, Jalr_i, Shift_i, ALUControl_i,
           Compare_i, imme_i, rdata1_i, rdata2_i, instr_i, addr_i, rd_i,
           rs1_i, rs2_i, mem_rd_i, mem_regwrite_i, mem_result_i, wb_rd_i,
           wb_regwrite_i, wb_result_i,
    input  alu_result_o, store_data_o, rd_o, RegWrite_o, instr_o,
           redirect_o, target_o, stall_o
  );

  modport slave (
    input  RegWrite_i, ALUSrc_i, Branch_i, J_i, Jalr_i, Shift_i, ALUControl_i,
           Compare_i, imme_i, rdata1_i, rdata2_i, instr_i, addr_i, rd_i,
           rs1_i, rs2_i, mem_rd_i, mem_regwrite_i, mem_result_i, wb_rd_i,
           wb_regwrite_i, wb_result_i,
    output alu_result_o, store_data_o, rd_o, RegWrite_o, instr_o,
           redirect_o, target_o, stall_o
  );
endinterface

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module      : ex_stage
// Description : RV32I execute stage: forwarding, ALU/shift, branch/jump
//               resolution and the EX/MEM latch. EX_SERIAL_SHIFT_EN selects a
//               1-bit/cycle shifter that stalls the front end while busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage (
  input  wire logic clk,
  input  wire logic rst_n,
  ex_stage_if.slave bus
);

  logic [31:0] w_fwd_a, w_fwd_b, w_op_b, w_alu, w_shift, w_result, w_link;
  logic [13:0] w_target, w_jalr_sum;
  logic        w_cmp, w_redirect;

  logic [31:0] r_alu_result, r_store_data, r_instr;
  logic [4:0]  r_rd;
  logic        r_regwrite, r_redirect;
  logic [13:0] r_target;

  // MEM is applied last so it wins over WB.
  always_comb begin
    w_fwd_a = bus.rdata1_i;
    w_fwd_b = bus.rdata2_i;
    if (bus.wb_regwrite_i && bus.wb_rd_i == bus.rs1_i && bus.rs1_i != 5'd0)
      w_fwd_a = bus.wb_result_i;
    if (bus.mem_regwrite_i && bus.mem_rd_i == bus.rs1_i && bus.rs1_i != 5'd0)
      w_fwd_a = bus.mem_result_i;
    if (bus.wb_regwrite_i && bus.wb_rd_i == bus.rs2_i && bus.rs2_i != 5'd0)
      w_fwd_b = bus.wb_result_i;
    if (bus.mem_regwrite_i && bus.mem_rd_i == bus.rs2_i && bus.rs2_i != 5'd0)
      w_fwd_b = bus.mem_result_i;
  end

  assign w_op_b = bus.ALUSrc_i ? bus.imme_i : w_fwd_b;

  always_comb begin
    case (bus.ALUControl_i)
      4'd0:    w_alu = w_fwd_a + w_op_b;
      4'd1:    w_alu = w_fwd_a - w_op_b;
      4'd2:    w_alu = w_fwd_a & w_op_b;
      4'd3:    w_alu = w_fwd_a | w_op_b;
      4'd4:    w_alu = w_fwd_a ^ w_op_b;
      4'd5:    w_alu = {31'd0, $signed(w_fwd_a) < $signed(w_op_b)};
      4'd6:    w_alu = {31'd0, w_fwd_a < w_op_b};
      4'd7:    w_alu = w_op_b;
      default: w_alu = 32'd0;
    endcase
  end

`ifdef EX_SERIAL_SHIFT_EN
  // Only zero-length shifts complete combinationally; the rest go to the FSM.
  assign w_shift = w_fwd_a;
`else
  always_comb begin
    case (bus.Shift_i)
      2'b01:   w_shift = w_fwd_a << w_op_b[4:0];
      2'b10:   w_shift = w_fwd_a >> w_op_b[4:0];
      2'b11:   w_shift = $unsigned($signed(w_fwd_a) >>> w_op_b[4:0]);
      default: w_shift = w_fwd_a;
    endcase
  end
`endif

  always_comb begin
    case (bus.Compare_i)
      3'b000:  w_cmp = (w_fwd_a == w_fwd_b);
      3'b001:  w_cmp = (w_fwd_a != w_fwd_b);
      3'b100:  w_cmp = ($signed(w_fwd_a) < $signed(w_fwd_b));
      3'b101:  w_cmp = ($signed(w_fwd_a) >= $signed(w_fwd_b));
      3'b110:  w_cmp = (w_fwd_a < w_fwd_b);
      3'b111:  w_cmp = (w_fwd_a >= w_fwd_b);
      default: w_cmp = 1'b0;
    endcase
  end

  assign w_redirect = (bus.Branch_i & w_cmp) | bus.J_i | bus.Jalr_i;
  assign w_jalr_sum = w_fwd_a[13:0] + bus.imme_i[13:0];
  assign w_target   = bus.Jalr_i ? {w_jalr_sum[13:1], 1'b0}
                                 : bus.addr_i + bus.imme_i[13:0];
  assign w_link     = {18'd0, bus.addr_i} + 32'd4;
  assign w_result   = (bus.J_i | bus.Jalr_i) ? w_link :
                      (bus.Shift_i != 2'b00) ? w_shift : w_alu;

`ifdef EX_SERIAL_SHIFT_EN
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_work, r_sv_store, r_sv_instr;
  logic [4:0]  r_count, r_sv_rd;
  logic [1:0]  r_op;
  logic        r_sv_regwrite;
  logic [31:0] w_step;
  logic        w_start;

  assign w_start = (r_state == S_IDLE) && (bus.Shift_i != 2'b00) &&
                   (w_op_b[4:0] != 5'd0);
  assign bus.stall_o = ~rst_n &
                       (w_start | ((r_state == S_SHIFT) && (r_count != 5'd1)));

  always_comb begin
    case (r_op)
      2'b01:   w_step = {r_work[30:0], 1'b0};
      2'b10:   w_step = {1'b0, r_work[31:1]};
      2'b11:   w_step = {r_work[31], r_work[31:1]};
      default: w_step = r_work;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state       <= S_IDLE;
      r_work        <= 32'd0;
      r_count       <= 5'd0;
      r_op          <= 2'b00;
      r_sv_store    <= 32'd0;
      r_sv_instr    <= 32'd0;
      r_sv_rd       <= 5'd0;
      r_sv_regwrite <= 1'b0;
      r_alu_result  <= 32'd0;
      r_store_data  <= 32'd0;
      r_instr       <= 32'd0;
      r_rd          <= 5'd0;
      r_regwrite    <= 1'b0;
      r_redirect    <= 1'b0;
      r_target      <= 14'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state       <= S_SHIFT;
            r_work        <= w_fwd_a;
            r_count       <= w_op_b[4:0];
            r_op          <= bus.Shift_i;
            r_sv_store    <= w_fwd_b;
            r_sv_instr    <= bus.instr_i;
            r_sv_rd       <= bus.rd_i;
            r_sv_regwrite <= bus.RegWrite_i;
            r_alu_result  <= 32'd0;
            r_instr       <= 32'd0;
            r_rd          <= 5'd0;
            r_regwrite    <= 1'b0;
            r_redirect    <= 1'b0;
          end else begin
            r_alu_result <= w_result;
            r_store_data <= w_fwd_b;
            r_instr      <= bus.instr_i;
            r_rd         <= bus.rd_i;
            r_regwrite   <= bus.RegWrite_i;
            r_redirect   <= w_redirect;
            r_target     <= w_target;
          end
        end
        default: begin
          r_work  <= w_step;
          r_count <= r_count - 5'd1;
          if (r_count == 5'd1) begin
            r_state      <= S_IDLE;
            r_alu_result <= w_step;
            r_store_data <= r_sv_store;
            r_instr      <= r_sv_instr;
            r_rd         <= r_sv_rd;
            r_regwrite   <= r_sv_regwrite;
            r_redirect   <= 1'b0;
          end else begin
            r_alu_result <= 32'd0;
            r_instr      <= 32'd0;
            r_rd         <= 5'd0;
            r_regwrite   <= 1'b0;
            r_redirect   <= 1'b0;
          end
        end
      endcase
    end
  end
`else
  assign bus.stall_o = 1'b0;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_alu_result <= 32'd0;
      r_store_data <= 32'd0;
      r_instr      <= 32'd0;
      r_rd         <= 5'd0;
      r_regwrite   <= 1'b0;
      r_redirect   <= 1'b0;
      r_target     <= 14'd0;
    end else begin
      r_alu_result <= w_result;
      r_store_data <= w_fwd_b;
      r_instr      <= bus.instr_i;
      r_rd         <= bus.rd_i;
      r_regwrite   <= bus.RegWrite_i;
      r_redirect   <= w_redirect;
      r_target     <= w_target;
    end
  end
`endif

  assign bus.alu_result_o = r_alu_result;
  assign bus.store_data_o = r_store_data;
  assign bus.instr_o      = r_instr;
  assign bus.rd_o         = r_rd;
  assign bus.RegWrite_o   = r_regwrite;
  assign bus.redirect_o   = r_redirect;
  assign bus.target_o     = r_target;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// Module      : tb_ex_stage
// Description : Scoreboard bench for ex_stage; follows EX_SERIAL_SHIFT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if bus();
  ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] res;
    logic        redir;
    logic [13:0] tgt;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] sd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_inputs();
    bus.RegWrite_i = 0; bus.ALUSrc_i = 0; bus.Branch_i = 0; bus.J_i = 0; bus.Jalr_i = 0;
    bus.Shift_i = 0; bus.ALUControl_i = 0; bus.Compare_i = 0;
    bus.imme_i = 0; bus.rdata1_i = 0; bus.rdata2_i = 0; bus.instr_i = 0; bus.addr_i = 0;
    bus.rd_i = 0; bus.rs1_i = 0; bus.rs2_i = 0;
    bus.mem_rd_i = 0; bus.mem_regwrite_i = 0; bus.mem_result_i = 0;
    bus.wb_rd_i = 0; bus.wb_regwrite_i = 0; bus.wb_result_i = 0;
  endtask

  task automatic push(input logic [31:0] res, input logic redir, input logic [13:0] tgt,
                      input logic [4:0] rd, input logic rw, input logic [31:0] sd);
    exp_t e;
    e.res = res; e.redir = redir; e.tgt = tgt; e.rd = rd; e.rw = rw; e.sd = sd;
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    check({tag, ".sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, ".res"},   bus.alu_result_o, e.res);
    check({tag, ".redir"}, 32'(bus.redirect_o), 32'(e.redir));
    if (e.redir) check({tag, ".tgt"}, 32'(bus.target_o), 32'(e.tgt));
    check({tag, ".rd"},    32'(bus.rd_o), 32'(e.rd));
    check({tag, ".rw"},    32'(bus.RegWrite_o), 32'(e.rw));
    check({tag, ".sd"},    bus.store_data_o, e.sd);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".res"},   bus.alu_result_o, 32'd0);
    check({tag, ".sd"},    bus.store_data_o, 32'd0);
    check({tag, ".rd"},    32'(bus.rd_o), 32'd0);
    check({tag, ".rw"},    32'(bus.RegWrite_o), 32'd0);
    check({tag, ".instr"}, bus.instr_o, 32'd0);
    check({tag, ".redir"}, 32'(bus.redirect_o), 32'd0);
    check({tag, ".tgt"},   32'(bus.target_o), 32'd0);
    check({tag, ".stall"}, 32'(bus.stall_o), 32'd0);
  endtask

  // Shift via immediate shamt; under the serial build also checks stall/bubbles
  // and that a forwarding change mid-shift is ignored.
  task automatic shift_test(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input int n, input logic [31:0] exp);
    @(negedge clk);
    clear_inputs();
    bus.Shift_i = op; bus.ALUSrc_i = 1; bus.imme_i = 32'(n);
    bus.rs1_i = 5'd8; bus.rdata1_i = a; bus.rs2_i = 5'd9; bus.rdata2_i = 32'h0000_00AB;
    bus.rd_i = 5'd12; bus.RegWrite_i = 1; bus.instr_i = 32'h4050_5613;
    push(exp, 1'b0, 14'd0, 5'd12, 1'b1, 32'h0000_00AB);
`ifdef EX_SERIAL_SHIFT_EN
    for (int i = 0; i < n; i++) begin
      #1;
      check({tag, ".stall_hi"}, 32'(bus.stall_o), 32'd1);
      if (i == 1) begin
        bus.mem_rd_i = 5'd8; bus.mem_regwrite_i = 1; bus.mem_result_i = 32'h1234_5678;
      end
      @(posedge clk); #1;
      check({tag, ".bubble_res"}, bus.alu_result_o, 32'd0);
      check({tag, ".bubble_rw"},  32'(bus.RegWrite_o), 32'd0);
    end
`endif
    #1;
    check({tag, ".stall_lo"}, 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    compare_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk); rst_n = 1'b0;

    // ADD, rs1 matches both MEM and WB: MEM value wins
    @(negedge clk); clear_inputs();
    bus.rs1_i = 5'd3; bus.rdata1_i = 32'd5; bus.rs2_i = 5'd4; bus.rdata2_i = 32'd7;
    bus.mem_rd_i = 5'd3; bus.mem_regwrite_i = 1; bus.mem_result_i = 32'h10;
    bus.wb_rd_i = 5'd3; bus.wb_regwrite_i = 1; bus.wb_result_i = 32'h99;
    bus.RegWrite_i = 1; bus.rd_i = 5'd7; bus.instr_i = 32'h0041_8133;
    push(32'h17, 1'b0, 14'd0, 5'd7, 1'b1, 32'd7);
    @(posedge clk); #1;
    compare_out("add_mem");
    check("add_mem.instr", bus.instr_o, 32'h0041_8133);

    // SUB, rs2 from WB while MEM has regwrite off
    @(negedge clk); clear_inputs();
    bus.ALUControl_i = 4'd1; bus.rs1_i = 5'd2; bus.rdata1_i = 32'h20;
    bus.rs2_i = 5'd6; bus.rdata2_i = 32'h3;
    bus.mem_rd_i = 5'd6; bus.mem_regwrite_i = 0; bus.mem_result_i = 32'hBAD;
    bus.wb_rd_i = 5'd6; bus.wb_regwrite_i = 1; bus.wb_result_i = 32'h100;
    bus.RegWrite_i = 1; bus.rd_i = 5'd10;
    push(32'hFFFF_FF20, 1'b0, 14'd0, 5'd10, 1'b1, 32'h100);
    @(posedge clk); #1;
    compare_out("sub_wb");

    // x0 never forwarded
    @(negedge clk); clear_inputs();
    bus.mem_rd_i = 5'd0; bus.mem_regwrite_i = 1; bus.mem_result_i = 32'hDEAD;
    bus.ALUSrc_i = 1; bus.imme_i = 32'd5; bus.RegWrite_i = 1; bus.rd_i = 5'd1;
    push(32'd5, 1'b0, 14'd0, 5'd1, 1'b1, 32'd0);
    @(posedge clk); #1;
    compare_out("x0_nofwd");

    // BEQ taken
    @(negedge clk); clear_inputs();
    bus.Branch_i = 1; bus.Compare_i = 3'b000; bus.ALUControl_i = 4'd1;
    bus.rs1_i = 5'd1; bus.rdata1_i = 32'h55; bus.rs2_i = 5'd2; bus.rdata2_i = 32'h55;
    bus.addr_i = 14'h100; bus.imme_i = 32'h20;
    push(32'd0, 1'b1, 14'h120, 5'd0, 1'b0, 32'h55);
    @(posedge clk); #1;
    compare_out("beq");

    // GEU 1 >= 0xFFFFFFFF is false; also shows BEQ redirect lasted one cycle
    @(negedge clk); clear_inputs();
    bus.Branch_i = 1; bus.Compare_i = 3'b111; bus.ALUControl_i = 4'd1;
    bus.rs1_i = 5'd1; bus.rdata1_i = 32'd1; bus.rs2_i = 5'd2; bus.rdata2_i = 32'hFFFF_FFFF;
    bus.addr_i = 14'h200; bus.imme_i = 32'h40;
    push(32'd2, 1'b0, 14'd0, 5'd0, 1'b0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    compare_out("geu");

    // BLT signed taken with negative offset wrapping in 14 bits
    @(negedge clk); clear_inputs();
    bus.Branch_i = 1; bus.Compare_i = 3'b100; bus.ALUControl_i = 4'd7;
    bus.rs1_i = 5'd1; bus.rdata1_i = 32'hFFFF_FFFF; bus.rs2_i = 5'd2; bus.rdata2_i = 32'd1;
    bus.addr_i = 14'h10; bus.imme_i = 32'hFFFF_FFFC;
    push(32'd1, 1'b1, 14'h000C, 5'd0, 1'b0, 32'd1);
    @(posedge clk); #1;
    compare_out("blt");

    // JALR clears bit 0 of the target
    @(negedge clk); clear_inputs();
    bus.Jalr_i = 1; bus.ALUSrc_i = 1; bus.rs1_i = 5'd1; bus.rdata1_i = 32'h203;
    bus.imme_i = 32'd4; bus.addr_i = 14'h40; bus.RegWrite_i = 1; bus.rd_i = 5'd1;
    push(32'h44, 1'b1, 14'h206, 5'd1, 1'b1, 32'd0);
    @(posedge clk); #1;
    compare_out("jalr");

    // JAL target wraps at 2^14
    @(negedge clk); clear_inputs();
    bus.J_i = 1; bus.addr_i = 14'h3FF0; bus.imme_i = 32'h20; bus.RegWrite_i = 1; bus.rd_i = 5'd1;
    push(32'h3FF4, 1'b1, 14'h0010, 5'd1, 1'b1, 32'd0);
    @(posedge clk); #1;
    compare_out("jal");

    // Random ALU ops, including unused codes
    for (int i = 0; i < 10; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b, imm;
      logic        src;
      c = 4'($urandom_range(0, 9)); a = $urandom; b = $urandom; imm = $urandom;
      src = 1'($urandom_range(0, 1));
      @(negedge clk); clear_inputs();
      bus.ALUControl_i = c; bus.ALUSrc_i = src; bus.imme_i = imm;
      bus.rs1_i = 5'd11; bus.rdata1_i = a; bus.rs2_i = 5'd12; bus.rdata2_i = b;
      bus.RegWrite_i = 1; bus.rd_i = 5'd13;
      push(alu_model(c, a, src ? imm : b), 1'b0, 14'd0, 5'd13, 1'b1, b);
      @(posedge clk); #1;
      compare_out($sformatf("alu_rand%0d_op%0d", i, c));
    end

    shift_test("sll0", 2'b01, 32'h0000_A5A5, 0, 32'h0000_A5A5);
    shift_test("sll1", 2'b01, 32'h0000_0001, 1, 32'h0000_0002);
    shift_test("srl4", 2'b10, 32'hF000_0000, 4, 32'h0F00_0000);
    shift_test("sra5", 2'b11, 32'h8000_0000, 5, 32'hFC00_0000);

    // Reset asserted during the third SHIFT cycle aborts the shift
    @(negedge clk); clear_inputs();
    bus.Shift_i = 2'b01; bus.ALUSrc_i = 1; bus.imme_i = 32'd10;
    bus.rs1_i = 5'd8; bus.rdata1_i = 32'd1; bus.RegWrite_i = 1; bus.rd_i = 5'd14;
    bus.instr_i = 32'h00A4_1713;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk); clear_inputs(); rst_n = 1'b0;

    @(negedge clk); clear_inputs();
    bus.rs1_i = 5'd1; bus.rdata1_i = 32'd100; bus.rs2_i = 5'd2; bus.rdata2_i = 32'd23;
    bus.RegWrite_i = 1; bus.rd_i = 5'd15;
    push(32'd123, 1'b0, 14'd0, 5'd15, 1'b1, 32'd23);
    @(posedge clk); #1;
    compare_out("add_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage between the ID/EX pipeline register and the EX/MEM boundary of the 5-stage RV32I core. It does the following:
- Resolves operand forwarding from MEM and WB.
- Performs ALU and shift operations.
- Evaluates branch and jump conditions and computes redirect targets.
- Registers its results into the EX/MEM latch.

An optional serial shifter trades shift latency for area and stalls the front end while it is busy.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous reset, **active-high** (asserted = 1).
- `RegWrite_i`, `ALUSrc_i`, `Branch_i`, `J_i`, `Jalr_i` in 1: control from ID/EX.
- `Shift_i` in 2: 00 none, 01 SLL, 10 SRL, 11 SRA.
- `ALUControl_i` in 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 PASSB; other codes give 0.
- `Compare_i` in 3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; other codes are never taken.
- `imme_i`, `rdata1_i`, `rdata2_i`, `instr_i` in 32: immediate, register operands, raw instruction.
- `addr_i` in 14: byte PC of the instruction.
- `rd_i`, `rs1_i`, `rs2_i` in 5: register indices.
- `mem_rd_i` in 5, `mem_regwrite_i` in 1, `mem_result_i` in 32: forwarding source from EX/MEM.
- `wb_rd_i` in 5, `wb_regwrite_i` in 1, `wb_result_i` in 32: forwarding source from MEM/WB.
- `alu_result_o` out 32: registered result (link address for J/Jalr).
- `store_data_o` out 32: registered forwarded rs2 value.
- `rd_o` out 5, `RegWrite_o` out 1, `instr_o` out 32: registered passthrough.
- `redirect_o` out 1: registered, one cycle per taken branch or jump.
- `target_o` out 14: registered redirect target.
- `stall_o` out 1: combinational; freezes IF/ID and ID/EX while high.

## Operation
- **Forwarding** applies to operands A and B:
  - MEM match: `mem_regwrite_i` and `mem_rd_i` == rs, with rs ≠ 0.
  - WB match: same test on the WB inputs.
  - MEM has priority over WB. Otherwise the `rdata` input is used.
- **Operand B (ALU)** = `ALUSrc_i` ? `imme_i` : forwarded rs2. `store_data_o` is always the forwarded rs2.
- **ALU** arithmetic wraps modulo 2^32. SLT/SLTU produce 0 or 1.
- **Shift** (`Shift_i` ≠ 0) overrides `ALUControl_i`. The shift amount is operand B[4:0].
- **Branch**:
  - Taken = `Branch_i` & compare(forwarded A, forwarded rs2).
  - Target = `addr_i` + `imme_i`[13:0].
- **Jumps**:
  - J: target = `addr_i` + `imme_i`[13:0].
  - Jalr: target = (A + `imme_i`)[13:0] with bit 0 cleared.
  - Both: `alu_result_o` = zero-extended `addr_i` + 4, and redirect is asserted.
- **Redirect arithmetic**: all 14-bit target arithmetic wraps modulo 2^14.
- **Shifter FSM**, states IDLE and SHIFT:
  - IDLE to SHIFT when a shift instruction is present and shamt N > 0. The working register is loaded with A and the counter with N.
  - In SHIFT, each cycle shifts one bit (SRA replicates bit 31) and decrements the counter.
  - When the counter = 1, the final step writes the EX/MEM latch and returns to IDLE.
  - Operands are sampled only at IDLE→SHIFT; later forwarding changes are ignored.
- **Stall**: `stall_o` = (IDLE & shift & N ≠ 0) | (SHIFT & count ≠ 1).
- **Bubble**: on every edge where `stall_o` = 1, the latch loads a bubble: `RegWrite_o` = 0, `redirect_o` = 0, `instr_o` = 0, `rd_o` = 0, `alu_result_o` = 0.

## Timing
- **Reset**: all outputs 0, FSM in IDLE, counter 0, `stall_o` = 0. Reset takes effect immediately (asynchronous), including mid-shift; the shift is aborted and no result is written.
- **Non-shift instructions and shift by 0**: presented in cycle k, results visible in cycle k+1 (1-cycle latency), with no stall.
- **Serial shift by N**:
  - `stall_o` is high in cycles k … k+N−1.
  - The result is visible in cycle k+N+1.
  - The next instruction is accepted at the edge ending cycle k+N.
- **Redirect**: `redirect_o`/`target_o` are valid in the same cycle as that instruction's `alu_result_o`. Flushing younger stages is the consumer's job.

## Configuration
- **`EX_SERIAL_SHIFT_EN` defined**: serial 1-bit/cycle shifter with the FSM and stall described above.
- **Undefined**:
  - Single-cycle barrel shifter; every shift has 1-cycle latency.
  - `stall_o` is tied to 0 and the FSM is removed.

## Test plan
- **ADD with MEM forward**: rs1 = 3 forwarded from MEM (`mem_result_i` = 0x10) while `rdata1_i` = 5, rs2 = 4 with `rdata2_i` = 7 -> `alu_result_o` = 0x17 the next cycle. When MEM and WB both match rs1, the MEM value is used.
- **rd = 0 not forwarded**: `mem_rd_i` = 0 with `mem_regwrite_i` = 1 while rs1 = 0 and `rdata1_i` = 0 -> operand A = 0, not `mem_result_i`.
- **BEQ and GEU**:
  - BEQ with A = rs2 = 0x55, `addr_i` = 0x100, `imme_i` = 0x20 -> `redirect_o` = 1 for one cycle, `target_o` = 0x120.
  - GEU with 1 vs 0xFFFFFFFF -> `redirect_o` = 0.
- **Jalr**: A = 0x203, `imme_i` = 4, `addr_i` = 0x40 -> `target_o` = 0x206, `alu_result_o` = 0x44, `redirect_o` = 1.
- **SRA with `EX_SERIAL_SHIFT_EN`**: SRA of 0x80000000 by 5 -> `stall_o` high for exactly 5 cycles with bubbles on the outputs, then `alu_result_o` = 0xFC000000. Without the macro, the same stimulus gives 1-cycle latency and no stall.
- **Reset mid-shift**: assert `rst_n` during the 3rd SHIFT cycle -> all outputs 0 and `stall_o` = 0 immediately. After release, a new ADD completes normally.
